// File: rtl/simple_cpu_pkg.sv
// Shared constants for the SimpleCPU: default bus widths, opcodes and the
// memory sequencer state encoding.
package simple_cpu_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_JMP = 2'b10;
    localparam logic [1:0] OP_INC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_LOAD = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_unit_if.sv
// CPU access port and byte-stream loader port of the memory unit.
interface mem_unit_if
    import simple_cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic              busy;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ld_start, ld_valid, ld_data,
        input  cpu_rdata, cpu_ack, ld_ready, ld_done, busy
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ld_start, ld_valid, ld_data,
        output cpu_rdata, cpu_ack, ld_ready, ld_done, busy
    );
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM with registered read; a write also returns
// the written data on rdata (write-first) so writes can be echoed back.
module mem_array #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata     <= mem[addr];
        end
    end
endmodule

// File: rtl/mem_unit.sv
// Memory sequencer: services CPU reads/writes with configurable wait states
// and fills memory from a byte-stream loader starting at address 0.
module mem_unit
    import simple_cpu_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic     clk,
    input  logic     reset,
    mem_unit_if.slave bus
);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    mem_state_t        state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_hold_q;
    logic              ld_done_q;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    // The array access happens on the edge that enters ACK, so the mux follows
    // whichever state precedes ACK: live bus inputs from IDLE, latched ones from WAIT.
    always_comb begin
        arr_we    = 1'b0;
        arr_addr  = bus.cpu_addr;
        arr_wdata = bus.cpu_wdata;
        unique case (state_q)
            ST_IDLE: arr_we = NO_WAIT && bus.cpu_req && !bus.ld_start && bus.cpu_we;
            ST_WAIT: begin
                arr_addr  = addr_q;
                arr_wdata = wdata_q;
                arr_we    = we_q && (cnt_q == 4'd0);
            end
            ST_ACK:  arr_addr = addr_q;
            ST_LOAD: begin
                arr_addr  = ptr_q;
                arr_wdata = bus.ld_data;
                arr_we    = bus.ld_valid && !bus.ld_start;
            end
            default: arr_we = 1'b0;
        endcase
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            ptr_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_hold_q <= '0;
            ld_done_q    <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.ld_start) begin
                        state_q <= ST_LOAD;
                        ptr_q   <= '0;
                    end else if (bus.cpu_req) begin
                        we_q    <= bus.cpu_we;
                        addr_q  <= bus.cpu_addr;
                        wdata_q <= bus.cpu_wdata;
                        if (NO_WAIT) begin
                            state_q <= ST_ACK;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_ACK: begin
                    // Keep the acked data visible after the pulse ends.
                    rdata_hold_q <= arr_rdata;
                    state_q      <= ST_IDLE;
                end
                ST_LOAD: begin
                    if (bus.ld_start) begin
                        ptr_q <= '0;
                    end else if (bus.ld_valid) begin
                        ptr_q <= ptr_q + 1'b1;
                        if (ptr_q == '1) begin
                            ld_done_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cpu_ack   = (state_q == ST_ACK);
    assign bus.cpu_rdata = (state_q == ST_ACK) ? arr_rdata : rdata_hold_q;
    assign bus.ld_ready  = (state_q == ST_LOAD);
    assign bus.ld_done   = ld_done_q;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit: one instance with one wait state and one
// with none, compared against a plain array model of memory contents.
module tb_mem_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_unit_if #(.ADDR_W(6), .DATA_W(8)) b1 ();
    mem_unit_if #(.ADDR_W(6), .DATA_W(8)) b0 ();

    mem_unit #(.ADDR_W(6), .DATA_W(8), .WAIT_CYCLES(1)) dut (
        .clk (clk), .reset (reset), .bus (b1.slave)
    );
    mem_unit #(.ADDR_W(6), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk (clk), .reset (reset), .bus (b0.slave)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] model1 [64];
    logic [7:0] model0 [64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ld(input logic s, input logic v, input logic [7:0] d);
        b1.ld_start = s; b0.ld_start = s;
        b1.ld_valid = v; b0.ld_valid = v;
        b1.ld_data  = d; b0.ld_data  = d;
    endtask

    task automatic drive(input bit sel, input logic r, input logic w,
                         input logic [5:0] a, input logic [7:0] d);
        if (sel) begin
            b0.cpu_req = r; b0.cpu_we = w; b0.cpu_addr = a; b0.cpu_wdata = d;
        end else begin
            b1.cpu_req = r; b1.cpu_we = w; b1.cpu_addr = a; b1.cpu_wdata = d;
        end
    endtask

    // One request; inputs are scrambled after acceptance to show they are latched.
    task automatic cpu_acc(input bit sel, input bit we, input logic [5:0] a,
                           input logic [7:0] d, output int lat, output logic [7:0] rd,
                           output logic ack_after, output logic [7:0] held);
        logic ack;
        drive(sel, 1'b1, we, a, d);
        lat = 0;
        do begin
            tick();
            lat++;
            drive(sel, 1'b1, 1'($urandom), 6'($urandom), 8'($urandom));
            ack = sel ? b0.cpu_ack : b1.cpu_ack;
        end while (!ack && lat < 20);
        rd = sel ? b0.cpu_rdata : b1.cpu_rdata;
        drive(sel, 1'b0, 1'b0, 6'($urandom), 8'($urandom));
        tick();
        ack_after = sel ? b0.cpu_ack : b1.cpu_ack;
        held      = sel ? b0.cpu_rdata : b1.cpu_rdata;
        $display("acc dut%0d we=%0d addr=%h wdata=%h -> rdata=%h lat=%0d", sel ? 0 : 1,
                 we, a, d, rd, lat);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 0, 0, 6'h00, 8'h00);
        drive(1, 0, 0, 6'h00, 8'h00);
        set_ld(0, 0, 8'h00);
        repeat (3) tick();
        vectors++;
        if ({b1.cpu_ack, b1.cpu_rdata, b1.ld_ready, b1.ld_done, b1.busy} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs_w1: got ack=%b rdata=%h rdy=%b done=%b busy=%b want all 0",
                     b1.cpu_ack, b1.cpu_rdata, b1.ld_ready, b1.ld_done, b1.busy);
        end
        vectors++;
        if ({b0.cpu_ack, b0.cpu_rdata, b0.ld_ready, b0.ld_done, b0.busy} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs_w0: got ack=%b rdata=%h rdy=%b done=%b busy=%b want all 0",
                     b0.cpu_ack, b0.cpu_rdata, b0.ld_ready, b0.ld_done, b0.busy);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load();
        int i = 0;
        int ready_cyc = 0;
        int guard = 0;
        logic rdy;
        set_ld(1, 0, 8'h00);
        tick();
        while (i < 64 && guard < 200) begin
            rdy = b1.ld_ready;
            if (rdy) ready_cyc++;
            set_ld(0, 1, 8'(i) ^ 8'hA5);
            tick();
            guard++;
            if (rdy) begin
                model1[i] = 8'(i) ^ 8'hA5;
                model0[i] = 8'(i) ^ 8'hA5;
                i++;
            end
        end
        set_ld(0, 0, 8'h00);
        $display("load A5 pattern: %0d bytes, ld_ready for %0d cycles", i, ready_cyc);
        vectors++;
        if (ready_cyc != 64) begin
            miscompares++;
            $display("FAIL load_ready_cycles: got %0d want 64", ready_cyc);
        end
        vectors++;
        if ({b1.ld_done, b1.busy, b1.ld_ready} !== 3'b100) begin
            miscompares++;
            $display("FAIL load_done_pulse: got done/busy/ready=%b want 100",
                     {b1.ld_done, b1.busy, b1.ld_ready});
        end
        vectors++;
        if (b0.ld_done !== 1'b1) begin
            miscompares++;
            $display("FAIL load_done_w0: got %b want 1", b0.ld_done);
        end
        tick();
        vectors++;
        if (b1.ld_done !== 1'b0) begin
            miscompares++;
            $display("FAIL load_done_width: got %b want 0", b1.ld_done);
        end
    endtask

    task automatic test_read_latency();
        int lat;
        logic [7:0] rd, held;
        logic ackw;
        cpu_acc(0, 0, 6'h05, 8'h00, lat, rd, ackw, held);
        vectors++;
        if (lat != 2) begin
            miscompares++;
            $display("FAIL read_latency: got %0d want 2", lat);
        end
        vectors++;
        if (rd !== 8'hA0) begin
            miscompares++;
            $display("FAIL read_data_05: got %h want a0", rd);
        end
        vectors++;
        if (ackw !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_width: got ack=%b a cycle after the pulse want 0", ackw);
        end
        vectors++;
        if (held !== 8'hA0) begin
            miscompares++;
            $display("FAIL rdata_hold: got %h want a0", held);
        end
    endtask

    task automatic test_write_read();
        int lat;
        logic [7:0] rd, held;
        logic ackw;
        cpu_acc(0, 1, 6'h3F, 8'h7E, lat, rd, ackw, held);
        model1[6'h3F] = 8'h7E;
        vectors++;
        if (rd !== 8'h7E || lat != 2) begin
            miscompares++;
            $display("FAIL write_through: got rdata=%h lat=%0d want 7e lat=2", rd, lat);
        end
        cpu_acc(0, 0, 6'h3F, 8'h00, lat, rd, ackw, held);
        vectors++;
        if (rd !== model1[6'h3F]) begin
            miscompares++;
            $display("FAIL readback_3f: got %h want %h", rd, model1[6'h3F]);
        end
        cpu_acc(0, 0, 6'h3E, 8'h00, lat, rd, ackw, held);
        vectors++;
        if (rd !== 8'h9B) begin
            miscompares++;
            $display("FAIL neighbour_3e: got %h want 9b", rd);
        end
    endtask

    task automatic test_random_access();
        int lat;
        logic [7:0] rd, held, d, exp;
        logic [5:0] a;
        logic ackw, we;
        for (int n = 0; n < 24; n++) begin
            we = 1'($urandom);
            a  = 6'($urandom);
            d  = 8'($urandom);
            exp = we ? d : model1[a];
            cpu_acc(0, we, a, d, lat, rd, ackw, held);
            if (we) model1[a] = d;
            vectors++;
            if (rd !== exp || lat != 2 || ackw !== 1'b0) begin
                miscompares++;
                $display("FAIL random_access: got rdata=%h lat=%0d ack_after=%b want %h lat=2 ack_after=0",
                         rd, lat, ackw, exp);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int lat;
        logic [7:0] rd, held;
        logic ackw;
        int acks = 0;
        drive(0, 1, 1, 6'h10, 8'hFF);
        tick();
        vectors++;
        if (b1.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_busy: got %b want 1", b1.busy);
        end
        reset = 1'b0;
        drive(0, 0, 0, 6'h00, 8'h00);
        #1;
        vectors++;
        if ({b1.busy, b1.cpu_ack} !== 2'b00) begin
            miscompares++;
            $display("FAIL async_reset: got busy/ack=%b want 00", {b1.busy, b1.cpu_ack});
        end
        tick();
        reset = 1'b1;
        repeat (3) begin
            tick();
            acks += int'(b1.cpu_ack);
        end
        vectors++;
        if (acks != 0) begin
            miscompares++;
            $display("FAIL no_ack_after_reset: got %0d acks want 0", acks);
        end
        cpu_acc(0, 0, 6'h10, 8'h00, lat, rd, ackw, held);
        vectors++;
        if (rd !== model1[6'h10]) begin
            miscompares++;
            $display("FAIL write_aborted: got %h want %h", rd, model1[6'h10]);
        end
    endtask

    task automatic test_stall_priority();
        int i = 0;
        int guard = 0;
        int dones = 0;
        int acks = 0;
        int lat = 0;
        bit restarted = 0;
        logic rdy, v, st;
        drive(0, 1, 0, 6'h00, 8'h00);
        set_ld(1, 0, 8'h00);
        tick();
        set_ld(0, 0, 8'h00);
        vectors++;
        if ({b1.busy, b1.ld_ready, b1.cpu_ack} !== 3'b110) begin
            miscompares++;
            $display("FAIL load_priority: got busy/ready/ack=%b want 110",
                     {b1.busy, b1.ld_ready, b1.cpu_ack});
        end
        while (i < 64 && guard < 600) begin
            rdy = b1.ld_ready;
            v = 1'b0;
            st = 1'b0;
            if (!restarted && i == 20) begin
                st = 1'b1;
                restarted = 1;
                set_ld(1, 0, 8'h00);
            end else begin
                v = 1'($urandom);
                set_ld(0, v, v ? 8'hC3 : 8'h3C);
            end
            tick();
            guard++;
            if (st) begin
                i = 0;
            end else if (v && rdy) begin
                model1[i] = 8'hC3;
                model0[i] = 8'hC3;
                i++;
            end
            if (i < 64) begin
                dones += int'(b1.ld_done);
                acks  += int'(b1.cpu_ack);
            end
        end
        set_ld(0, 0, 8'h00);
        $display("load C3 stalled: %0d bytes in %0d cycles", i, guard);
        vectors++;
        if (dones != 0 || acks != 0 || b1.ld_done !== 1'b1) begin
            miscompares++;
            $display("FAIL stalled_load: got early dones=%0d acks=%0d final done=%b want 0 0 1",
                     dones, acks, b1.ld_done);
        end
        do begin
            tick();
            lat++;
        end while (!b1.cpu_ack && lat < 20);
        vectors++;
        if (lat != 2 || b1.cpu_rdata !== model1[0]) begin
            miscompares++;
            $display("FAIL pending_read: got lat=%0d rdata=%h want lat=2 rdata=%h",
                     lat, b1.cpu_rdata, model1[0]);
        end
        drive(0, 0, 0, 6'h00, 8'h00);
        tick();
    endtask

    task automatic test_no_wait();
        int lat;
        logic [7:0] rd, held, d, exp;
        logic [5:0] a;
        logic ackw, we;
        for (int n = 0; n < 12; n++) begin
            we = 1'($urandom);
            a  = 6'($urandom);
            d  = 8'($urandom);
            exp = we ? d : model0[a];
            cpu_acc(1, we, a, d, lat, rd, ackw, held);
            if (we) model0[a] = d;
            vectors++;
            if (rd !== exp || lat != 1 || ackw !== 1'b0) begin
                miscompares++;
                $display("FAIL no_wait_access: got rdata=%h lat=%0d ack_after=%b want %h lat=1 ack_after=0",
                         rd, lat, ackw, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] a, prev;
        a = 6'($urandom);
        prev = a;
        drive(1, 1, 0, a, 8'h00);
        for (int k = 1; k <= 16; k++) begin
            tick();
            vectors++;
            if (b0.cpu_ack !== 1'(k % 2)) begin
                miscompares++;
                $display("FAIL b2b_ack_cycle%0d: got %b want %0d", k, b0.cpu_ack, k % 2);
            end
            if (k % 2 == 1) begin
                vectors++;
                if (b0.cpu_rdata !== model0[prev]) begin
                    miscompares++;
                    $display("FAIL b2b_rdata_cycle%0d: got %h want %h", k, b0.cpu_rdata, model0[prev]);
                end
            end
            a = 6'($urandom);
            drive(1, 1, 0, a, 8'h00);
            if (k % 2 == 0) prev = a;
        end
        drive(1, 0, 0, 6'h00, 8'h00);
        tick();
        $display("back-to-back: 16 cycles on zero-wait instance");
    endtask

    initial begin
        test_reset();
        test_load();
        test_read_latency();
        test_write_read();
        test_random_access();
        test_reset_mid_write();
        test_stall_priority();
        test_no_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
